// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: pops show-ahead FIFO words into a 2-entry skid buffer
// and presents them as a registered valid/ready stream. FIFO_RD_CNT_EN adds rd_cnt.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  r_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
`ifdef FIFO_RD_CNT_EN
  output logic [CNT_WIDTH-1:0]  rd_cnt,
`endif
  output logic [1:0]            level
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   head_q, head_d;
  logic [DATA_WIDTH-1:0]   skid_q, skid_d;
  logic                    valid_q, valid_d;
  logic                    push, pop;

  // Pop strobe depends only on registered state and empty, never on m_ready.
  assign r_en    = !rrst && !empty && (state_q != ST_TWO);
  assign push    = r_en;
  assign pop     = valid_q && m_ready;
  assign m_data  = head_q;
  assign m_valid = valid_q;
  assign level   = state_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          head_d  = fifo_rdata;
        end
      end
      ST_ONE: begin
        if (push && !pop) begin
          state_d = ST_TWO;
          skid_d  = fifo_rdata;
        end else if (push && pop) begin
          head_d  = fifo_rdata;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_d = ST_ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign rd_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a modelled show-ahead FIFO feeds the DUT,
// expected words are queued on load and checked by a monitor on each handshake.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rrst;
  logic          empty;
  logic [DW-1:0] fifo_rdata;
  logic          r_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [1:0]    level;
`ifdef FIFO_RD_CNT_EN
  logic [3:0]    rd_cnt;
`endif

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (4)
  ) dut (
    .rclk       (clk),
    .rrst       (rrst),
    .empty      (empty),
    .fifo_rdata (fifo_rdata),
    .r_en       (r_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
`ifdef FIFO_RD_CNT_EN
    .rd_cnt     (rd_cnt),
`endif
    .level      (level)
  );

  always #5 clk = ~clk;

  // FIFO model: bench writes at wptr, DUT pops advance rptr at the edge
  logic [DW-1:0] mem [256];
  int            wptr = 0;
  int            rptr = 0;
  assign empty      = (rptr == wptr);
  assign fifo_rdata = mem[rptr % 256];

  always @(posedge clk) if (r_en) rptr <= rptr + 1;

  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            hs_since_rst = 0;
  bit            started = 1'b0;
  bit            hold_pend = 1'b0;
  logic [DW-1:0] hold_data;

  always @(posedge clk) begin
    if (rrst) hs_since_rst <= 0;
    else if (m_valid && m_ready) hs_since_rst <= hs_since_rst + 1;
  end

  // Monitor: scoreboard on handshakes plus per-cycle invariants
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (r_en && (empty || level == 2'd2 || rrst)) begin
        errors++;
        $display("FAIL ren_guard: r_en=%0b empty=%0b level=%0d rrst=%0b", r_en, empty, level, rrst);
      end
      checks++;
      if (m_valid !== (level != 2'd0) || level === 2'd3) begin
        errors++;
        $display("FAIL valid_level: m_valid=%0b level=%0d", m_valid, level);
      end
      if (hold_pend && m_valid) begin
        checks++;
        if (m_data !== hold_data) begin
          errors++;
          $display("FAIL hold: m_data=%h required %h", m_data, hold_data);
        end
      end
      if (!rrst && m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got %h, required none", m_data);
        end else begin
          if (m_data !== exp_q[0]) begin
            errors++;
            $display("FAIL sb_data: got %h required %h", m_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      hold_pend = !rrst && m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    mem[wptr % 256] = v;
    wptr = wptr + 1;
    exp_q.push_back(v);
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic drain(input int maxc, input bit alt, input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || level != 2'd0) && n < maxc) begin
      if (alt) m_ready = ~m_ready;
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || level != 2'd0) begin
      errors++;
      $display("FAIL %s_timeout: left=%0d level=%0d required 0", nm, exp_q.size(), level);
    end
  endtask

  initial begin
    int rp0;
    int exp_ren [5] = '{1, 1, 1, 0, 0};
    rrst    = 1'b1;
    m_ready = 1'b0;
    push_word(8'h5A);
    // Reset with a non-empty FIFO
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      started = 1'b1;
      @(negedge clk);
      check("rst_ren", 16'(r_en), 16'd0);
      check("rst_valid", 16'(m_valid), 16'd0);
      check("rst_data", 16'(m_data), 16'h00);
      check("rst_level", 16'(level), 16'd0);
    end
    tick();
    rrst    = 1'b0;
    m_ready = 1'b1;
    drain(20, 1'b0, "post_rst");

    // Streaming with m_ready=1
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stream_ren", 16'(r_en), 16'(exp_ren[c]));
      check("stream_level", 16'(level == 2'd2), 16'd0);
    end
    tick();
    drain(20, 1'b0, "stream");

    // Backpressure
    m_ready = 1'b0;
    rp0 = rptr;
    for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
    repeat (4) tick();
    check("bp_pops", 16'(rptr - rp0), 16'd2);
    check("bp_level", 16'(level), 16'd2);
    check("bp_data", 16'(m_data), 16'h00A0);
    check("bp_ren", 16'(r_en), 16'd0);
    m_ready = 1'b1;
    drain(30, 1'b0, "bp");

    // Alternating ready
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(i));
    drain(60, 1'b1, "alt");

    // Reset while holding two words
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i));
    repeat (4) tick();
    check("prerst_level", 16'(level), 16'd2);
    rrst = 1'b1;
    tick();
    check("midrst_level", 16'(level), 16'd0);
    check("midrst_valid", 16'(m_valid), 16'd0);
    check("midrst_data", 16'(m_data), 16'h00);
    exp_q.delete();
    for (int i = rptr; i < wptr; i++) exp_q.push_back(mem[i % 256]);
    check("midrst_left", 16'(exp_q.size()), 16'd2);
    rrst    = 1'b0;
    m_ready = 1'b1;
    drain(20, 1'b0, "after_rst");

    // Long stream: 17 handshakes since the last reset
    for (int i = 0; i < 15; i++) push_word(8'h40 + 8'(i));
    drain(40, 1'b0, "long");
    tick();
`ifdef FIFO_RD_CNT_EN
    check("rd_cnt", 16'(rd_cnt), 16'(4'(hs_since_rst)));
    check("rd_cnt_wrap", 16'(rd_cnt), 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors + 0);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Single-clock read-side consumer for the asynchronous FIFO. It pops words from the FIFO read port (show-ahead memory output, `empty` flag, `r_en` pop strobe) and presents them downstream as a registered valid/ready stream through a 2-entry skid buffer. It sits in the read clock domain, directly after the FIFO memory and read-pointer logic, and decouples `m_ready` from `r_en` with no combinational path between them.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO memory.
- `CNT_WIDTH`, 16, width of the popped-word counter (used only with `FIFO_RD_CNT_EN`).

- `rclk`  input  1  read-domain clock; all state updates on its rising edge.
- `rrst`  input  1  synchronous, active-high reset.
- `empty`  input  1  FIFO empty flag, already in the `rclk` domain.
- `fifo_rdata`  input  DATA_WIDTH  FIFO memory output at the current read pointer; valid whenever `empty`=0.
- `r_en`  output  1  pop strobe to the FIFO; one word is consumed per cycle it is high.
- `m_data`  output  DATA_WIDTH  downstream data (registered).
- `m_valid`  output  1  downstream valid (registered).
- `m_ready`  input  1  downstream ready.
- `level`  output  2  number of words buffered: 0, 1 or 2.
- `rd_cnt`  output  CNT_WIDTH  total accepted downstream handshakes. Present only with `FIFO_RD_CNT_EN`.

## Operation
- Storage is a 2-entry buffer. Entry 0 is the head and drives `m_data`; entry 1 is the skid slot.
- FSM states:
  - EMPTY (`level`=0, `m_valid`=0).
  - ONE (`level`=1, `m_valid`=1).
  - TWO (`level`=2, `m_valid`=1).
- Pop rule: `r_en` = !`rrst` && !`empty` && (state != TWO). It is combinational from registered state and `empty` only, never from `m_ready`.
- Push: when `r_en`=1, `fifo_rdata` is captured at the edge.
- Handshake: a word transfers when `m_valid` && `m_ready` at the edge.
- Transitions, with push = `r_en` and pop = handshake:
  - EMPTY: push → ONE, and the word goes to the head.
  - ONE: push with no pop → TWO, and the word goes to the skid slot.
  - ONE: pop with no push → EMPTY.
  - ONE: push and pop → stays ONE, and the new word replaces the head.
  - TWO: pop → ONE, and the skid word moves to the head. No push is possible in TWO.
- Ordering: strictly FIFO. Output order equals pop order.
- `m_data` is held stable while `m_valid`=1 and `m_ready`=0.
- With `m_ready` held at 1 and a steady supply, throughput is one word per cycle (state stays ONE).
- Underflow is impossible by construction: `r_en` is never high while `empty`=1.
- Overflow is impossible by construction: no push occurs in TWO.

## Timing
- Reset (`rrst`=1 at an edge):
  - State → EMPTY, `m_valid`=0, `m_data`=0, skid entry=0, `level`=0.
  - `rd_cnt`=0.
  - `r_en` is forced to 0 in the same cycle `rrst` is high.
- Reset mid-operation: buffered words are discarded. The FIFO pointers are not touched by this block.
- Latency: `empty` falls in cycle N → `r_en`=1 in cycle N → `m_valid`=1 and `m_data`=word from the edge ending cycle N (1 cycle).
- Backpressure: with `m_ready`=0, at most 2 words are popped, then `r_en` stays 0.
- Recovery: `m_ready` rising in cycle M → handshake at the end of M → state leaves TWO → `r_en` can be high in cycle M+1.
- `level` is registered and is an exact encoding of the FSM state.

## Configuration
- `FIFO_RD_CNT_EN` defined:
  - `rd_cnt` port exists.
  - It increments by 1 on every downstream handshake and wraps modulo 2^CNT_WIDTH.
  - It resets to 0.
- `FIFO_RD_CNT_EN` undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset with `empty`=0 and `rrst`=1 for 2 cycles → `r_en`=0, `m_valid`=0, `m_data`=0, `level`=0 throughout.
- Streaming: FIFO holds 0x11,0x22,0x33 and `m_ready`=1 → `r_en` high 3 consecutive cycles; `m_data` shows 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first pop; `level` is never 2.
- Backpressure: FIFO holds 0xA0–0xA4 and `m_ready`=0 → exactly 2 pops, `level`=2, `m_data`=0xA0 held. Raising `m_ready` then delivers 0xA0–0xA4 in order with none lost or duplicated.
- Alternating `m_ready` (1,0,1,0…) over 8 words 0x00–0x07 → output order is 0x00–0x07, and `r_en` is never high when `level`=2 or `empty`=1.
- Reset asserted while `level`=2 → next cycle `level`=0 and `m_valid`=0; the following FIFO words arrive normally after `rrst` drops.
- `FIFO_RD_CNT_EN` with CNT_WIDTH=4: 17 handshakes → `rd_cnt`=1 (wrap).
